// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end with PC-tagged FIFO and redirect flush
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [63:0]   r_mem [DEPTH];

  logic [CW-1:0] w_used;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;

  // Credit covers both buffered and in-flight words, so a response can always be pushed.
  assign w_used       = r_inflight + r_count;
  assign imem_req_o   = rst_i & start_i & ~redirect_i & (w_used < CW'(DEPTH));
  assign imem_addr_o  = r_fetch_pc;
  assign w_grant      = imem_req_o & imem_gnt_i;
  assign w_rsp        = imem_rvalid_i & (r_inflight != '0);
  assign w_push       = w_rsp & (r_discard == '0) & ~redirect_i;
  assign w_pop        = inst_valid_o & inst_ready_i & ~redirect_i;

  assign inst_valid_o = (r_count != '0);
  assign inst_o       = r_mem[r_head][31:0];
  assign inst_pc_o    = r_mem[r_head][63:32];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_grant) - CW'(w_rsp);
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        r_rsp_pc   <= {redirect_pc_i[31:2], 2'b00};
        r_discard  <= r_inflight - CW'(w_rsp);
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CW'(1);
        if (w_push) begin
          r_mem[r_tail] <= {r_rsp_pc, imem_rdata_i};
          r_tail        <= r_tail + AW'(1);
          r_rsp_pc      <= r_rsp_pc + 32'd4;
        end
        if (w_pop) r_head <= r_head + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with an in-order latency memory model
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int n_grants = 0;
  int first_grant = -1;
  int first_valid = -1;
  logic gnt_en = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [63:0] popped[$];

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_ready_i(inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mdata(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
    imem_gnt_i = gnt_en;
    #1;
    if (imem_req_o && imem_gnt_i) begin
      mq.push_back(req_t'{addr: imem_addr_o, due: cyc + lat});
      n_grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    if (inst_valid_o && first_valid < 0) first_valid = cyc;
    if (inst_valid_o && inst_ready_i && !redirect_i) popped.push_back({inst_pc_o, inst_o});
    @(negedge clk_i);
    cyc++;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; start_i = 1'b0; inst_ready_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = 32'h0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    imem_gnt_i = 1'b0; gnt_en = 1'b0;
    mq.delete(); popped.delete();
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    cyc = 0; lat = 1; n_grants = 0; first_grant = -1; first_valid = -1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; start_i = 1'b1; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 00000000", inst_o); end
    checks++; if (inst_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", inst_pc_o); end
    do_reset();
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req_o); end
    start_i = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL start_req: got %b expected 1", imem_req_o); end
    start_i = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b1; gnt_en = 1'b1; lat = 1;
    repeat (10) step();
    checks++; if (first_grant !== 0) begin errors++; $display("FAIL stream_first_grant: got %0d expected 0", first_grant); end
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL stream_first_valid: got %0d expected 2", first_valid); end
    checks++; if (popped.size() !== 8) begin errors++; $display("FAIL stream_pop_count: got %0d expected 8", popped.size()); end
    for (int k = 0; k < 8; k++) begin
      logic [31:0] pc;
      pc = 32'(4 * k);
      checks++;
      if (popped[k] !== {pc, mdata(pc)}) begin
        errors++; $display("FAIL stream_entry%0d: got %h expected %h", k, popped[k], {pc, mdata(pc)});
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    start_i = 1'b1; inst_ready_i = 1'b0; gnt_en = 1'b1; lat = 1;
    repeat (8) step();
    checks++; if (n_grants !== 4) begin errors++; $display("FAIL full_grants: got %0d expected 4", n_grants); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL full_req_low: got %b expected 0", imem_req_o); end
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", inst_valid_o); end
    inst_ready_i = 1'b1;
    step();
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL full_req_resume: got %b expected 1", imem_req_o); end
    repeat (6) step();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] pc;
      pc = 32'(4 * k);
      checks++;
      if (popped[k] !== {pc, mdata(pc)}) begin
        errors++; $display("FAIL full_entry%0d: got %h expected %h", k, popped[k], {pc, mdata(pc)});
      end
    end
  endtask

  task automatic test_redirect_stale();
    do_reset();
    lat = 3; gnt_en = 1'b1; inst_ready_i = 1'b1; start_i = 1'b1;
    step(); step();
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stale_redirect_req: got %b expected 0", imem_req_o); end
    step();
    redirect_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL stale_valid_after: got %b expected 0", inst_valid_o); end
    checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL stale_addr: got %h expected 00000100", imem_addr_o); end
    first_valid = -1;
    popped.delete();
    repeat (8) step();
    checks++; if (first_valid !== 7) begin errors++; $display("FAIL stale_first_valid: got %0d expected 7", first_valid); end
    checks++; if (popped[0] !== {32'h100, mdata(32'h100)}) begin errors++; $display("FAIL stale_entry0: got %h expected %h", popped[0], {32'h100, mdata(32'h100)}); end
    checks++; if (popped[1] !== {32'h104, mdata(32'h104)}) begin errors++; $display("FAIL stale_entry1: got %h expected %h", popped[1], {32'h104, mdata(32'h104)}); end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    lat = 2; gnt_en = 1'b1; inst_ready_i = 1'b1; start_i = 1'b1;
    repeat (5) step();
    checks++; if (popped.size() !== 2) begin errors++; $display("FAIL collide_pre_pops: got %0d expected 2", popped.size()); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
    step();
    redirect_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL collide_valid_after: got %b expected 0", inst_valid_o); end
    checks++; if (imem_addr_o !== 32'h200) begin errors++; $display("FAIL collide_addr: got %h expected 00000200", imem_addr_o); end
    popped.delete();
    first_valid = -1;
    repeat (5) step();
    checks++; if (first_valid !== 9) begin errors++; $display("FAIL collide_first_valid: got %0d expected 9", first_valid); end
    checks++; if (popped[0] !== {32'h200, mdata(32'h200)}) begin errors++; $display("FAIL collide_entry0: got %h expected %h", popped[0], {32'h200, mdata(32'h200)}); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    lat = 3; gnt_en = 1'b1; inst_ready_i = 1'b1; start_i = 1'b1;
    step(); step();
    start_i = 1'b0; rst_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mid_reset_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_reset_addr: got %h expected 00000000", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", inst_valid_o); end
    step();
    rst_i = 1'b1;
    first_valid = -1;
    step(); step();
    checks++; if (first_valid !== -1) begin errors++; $display("FAIL mid_stale_valid: got %0d expected -1", first_valid); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL mid_restart_addr: got %h expected 00000000", imem_addr_o); end
    start_i = 1'b1; lat = 1;
    repeat (4) step();
    checks++; if (first_valid !== 7) begin errors++; $display("FAIL mid_first_valid: got %0d expected 7", first_valid); end
    checks++; if (popped[0] !== {32'h0, mdata(32'h0)}) begin errors++; $display("FAIL mid_entry0: got %h expected %h", popped[0], {32'h0, mdata(32'h0)}); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_stale();
    test_redirect_collide();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the RISC-V core. It owns the fetch PC and issues word requests to instruction memory over a valid/grant handshake with in-order, variable-latency responses. Returned instructions are buffered, each tagged with its PC, in a small FIFO that feeds decode. Branch/jump redirects flush the buffer and discard responses still in flight.

## Interface
- DEPTH, 4, FIFO entries and maximum in-flight plus buffered instructions; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  fetch enable; low stops new requests, in-flight responses still accepted
- imem_req_o  out  1  request valid
- imem_addr_o  out  32  request word address, bits [1:0] always 0
- imem_gnt_i  in  1  memory accepts request this cycle when imem_req_o high
- imem_rvalid_i  in  1  response valid, one per granted request, in order, ≥1 cycle after grant
- imem_rdata_i  in  32  response instruction
- redirect_i  in  1  flush and restart fetch
- redirect_pc_i  in  32  new fetch PC, bits [1:0] ignored (forced 0)
- inst_valid_o  out  1  FIFO head valid
- inst_o  out  32  head instruction
- inst_pc_o  out  32  head instruction PC
- inst_ready_i  in  1  decode consumes head when inst_valid_o high

## Operation
- State: fetch_pc, rsp_pc (PC of next kept response), inflight count, discard count, FIFO count, DEPTH×64-bit storage. Counters are $clog2(DEPTH)+1 bits.
- Issue: imem_req_o = start_i & ~redirect_i & (inflight + count < DEPTH). imem_addr_o = fetch_pc. On req & gnt: fetch_pc += 4, inflight += 1.
- Response: on imem_rvalid_i, inflight −= 1. If discard ≠ 0, drop and discard −= 1. Otherwise push {rsp_pc, imem_rdata_i} and rsp_pc += 4. The credit rule guarantees a push never overflows.
- imem_rvalid_i with inflight = 0 is a protocol error. The response is ignored and no counter changes. This covers stale responses after reset.
- Pop: on inst_valid_o & inst_ready_i, advance the head and count −= 1. Simultaneous push and pop leaves count unchanged.
- inst_valid_o = (count ≠ 0). inst_o and inst_pc_o come from the head entry.
- Redirect (highest priority):
  - FIFO count → 0.
  - fetch_pc and rsp_pc → {redirect_pc_i[31:2], 2'b00}.
  - discard → inflight − imem_rvalid_i.
  - Any pop or response in the redirect cycle is void.
  - No request is issued in the redirect cycle.
- start_i low: issue stops and everything else continues. The FIFO drains and in-flight responses are pushed.
- Wrap-around: fetch_pc and rsp_pc wrap modulo 2^32. FIFO pointers wrap modulo DEPTH.

## Timing
- Reset (rst_i low, async):
  - imem_req_o = 0, imem_addr_o = RESET_PC.
  - inst_valid_o = 0, inst_o = 0, inst_pc_o = 0.
  - All counters and storage cleared.
  - fetch_pc and rsp_pc = RESET_PC.
- Reset assertion mid-operation takes effect immediately, with no completion of pending work.
- imem_req_o is combinational from registered state, start_i and redirect_i. All other outputs are registered or come straight from FIFO storage.
- Latency with 1-cycle memory: grant in cycle N → rvalid N+1 → inst_valid_o N+2.
- Throughput with 1-cycle memory and a consumer ready every cycle: one instruction per cycle.
- After a redirect in cycle R:
  - inst_valid_o = 0 in R+1.
  - First request to redirect_pc_i in R+1 if start_i is high.
  - Earliest new instruction at R+3.
- FIFO full with consumer stalled: imem_req_o stays low until a pop frees credit. It reasserts the cycle after the pop.

## Test plan
- Reset then start_i = 1, memory grants every cycle with 1-cycle latency, ready = 1 → inst_pc_o = 0x0, 0x4, 0x8, … on consecutive cycles; first inst_valid_o two cycles after the first grant.
- ready = 0 with DEPTH = 4 → exactly 4 grants, then imem_req_o stays low. Raise ready → 4 pops in order, and requests resume one cycle after the first pop.
- Memory latency 3 cycles, 2 in flight, redirect_i to 0x100 → both stale responses dropped; next inst_pc_o = 0x100 with the data returned for address 0x100.
- Redirect in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, discard = inflight − 1.
- redirect_pc_i = 0x203 → imem_addr_o = 0x200 and inst_pc_o = 0x200.
- Assert rst_i low mid-stream with 2 in flight, then release and drive stale rvalid → responses ignored; fetch restarts at RESET_PC and inst_valid_o stays 0 until the first legitimate response.
